// File: rtl/exercise_decision.sv
// exercise_decision: early-exercise decision for Longstaff-Schwartz style pricing.
// Evaluates the continuation value C = b0 + b1*x + b2*x^2 in QINT.QFRAC fixed
// point for each path of a batch, compares it with the immediate payoff and
// emits the updated cash flow. Three-stage pipeline with valid/ready
// handshakes on the beta, sample and result interfaces.
module exercise_decision #(
    parameter int WIDTH   = 32,
    parameter int QINT    = 16,
    parameter int QFRAC   = 16,
    parameter int N_PATHS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beta_valid,
    output logic                          beta_ready,
    input  logic signed [WIDTH-1:0]       beta [0:2],
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic signed [WIDTH-1:0]       x_in,
    input  logic signed [WIDTH-1:0]       payoff_in,
    input  logic signed [WIDTH-1:0]       cf_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic signed [WIDTH-1:0]       cf_out,
    output logic                          exercise_out,
    output logic [$clog2(N_PATHS):0]      path_idx_out,
    output logic                          done
);

    localparam int IDXW = $clog2(N_PATHS) + 1;
    // Stage-1 products keep their full 2*WIDTH range, stage-2 products 3*WIDTH,
    // so nothing wraps before the final saturation.
    localparam int PW = 2 * WIDTH;
    localparam int TW = 3 * WIDTH;
    localparam int SW = TW + 1;
    // Saturation range of the QINT.QFRAC format, never wider than the bus.
    localparam int FMT_W   = QINT + QFRAC;
    localparam int SAT_BIT = (FMT_W < WIDTH) ? FMT_W - 1 : WIDTH - 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW - SAT_BIT){1'b0}}, {SAT_BIT{1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW - SAT_BIT){1'b1}}, {SAT_BIT{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DRAIN
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] b0_q, b1_q, b2_q;
    logic [IDXW-1:0]         accepted;
    logic                    en;
    logic                    accept;
    logic                    last_out;

    // Stage 1 registers
    logic                    v_s1;
    logic signed [PW-1:0]    x2_s1, b1x_s1;
    logic signed [WIDTH-1:0] pay_s1, cf_s1;
    logic [IDXW-1:0]         idx_s1;
    logic signed [PW-1:0]    x2_d, b1x_d;

    // Stage 2 registers
    logic                    v_s2;
    logic signed [TW-1:0]    b2x2_s2, s01_s2;
    logic signed [WIDTH-1:0] pay_s2, cf_s2;
    logic [IDXW-1:0]         idx_s2;
    logic signed [TW-1:0]    b2x2_d, s01_d;

    // Stage 3 combinational results
    logic signed [SW-1:0]    c_sum;
    logic signed [WIDTH-1:0] c_sat;
    logic                    ex_d;

    assign en        = !valid_out || ready_in;
    assign ready_out = (state == EVAL) && en && (accepted < IDXW'(N_PATHS));
    assign accept    = valid_in && ready_out;
    assign last_out  = (state == DRAIN) && valid_out && ready_in &&
                       (path_idx_out == IDXW'(N_PATHS - 1));

    // Control FSM: beta latch, accept counter, done pulse and beta_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beta_ready <= 1'b1;
            done       <= 1'b0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            accepted   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (beta_valid && beta_ready) begin
                        b0_q       <= beta[0];
                        b1_q       <= beta[1];
                        b2_q       <= beta[2];
                        accepted   <= '0;
                        beta_ready <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (accept) begin
                        accepted <= accepted + 1'b1;
                        if (accepted == IDXW'(N_PATHS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_out) begin
                        done       <= 1'b1;
                        beta_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    beta_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Stage 1 arithmetic: x^2 and b1*x, floor-shifted back to QFRAC
    always_comb begin
        x2_d  = (PW'(x_in) * PW'(x_in)) >>> QFRAC;
        b1x_d = (PW'(b1_q) * PW'(x_in)) >>> QFRAC;
    end

    // Stage 1 register: sample capture with payoff, cash flow and index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_s1   <= 1'b0;
            x2_s1  <= '0;
            b1x_s1 <= '0;
            pay_s1 <= '0;
            cf_s1  <= '0;
            idx_s1 <= '0;
        end else if (en) begin
            v_s1   <= accept;
            x2_s1  <= x2_d;
            b1x_s1 <= b1x_d;
            pay_s1 <= payoff_in;
            cf_s1  <= cf_in;
            idx_s1 <= accepted;
        end
    end

    // Stage 2 arithmetic: b2*x^2 and b0 + b1*x
    always_comb begin
        b2x2_d = (TW'(b2_q) * TW'(x2_s1)) >>> QFRAC;
        s01_d  = TW'(b0_q) + TW'(b1x_s1);
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_s2    <= 1'b0;
            b2x2_s2 <= '0;
            s01_s2  <= '0;
            pay_s2  <= '0;
            cf_s2   <= '0;
            idx_s2  <= '0;
        end else if (en) begin
            v_s2    <= v_s1;
            b2x2_s2 <= b2x2_d;
            s01_s2  <= s01_d;
            pay_s2  <= pay_s1;
            cf_s2   <= cf_s1;
            idx_s2  <= idx_s1;
        end
    end

    // Stage 3 arithmetic: saturated continuation value and exercise decision
    always_comb begin
        c_sum = SW'(s01_s2) + SW'(b2x2_s2);
        if (c_sum > SAT_MAX) begin
            c_sat = SAT_MAX[WIDTH-1:0];
        end else if (c_sum < SAT_MIN) begin
            c_sat = SAT_MIN[WIDTH-1:0];
        end else begin
            c_sat = c_sum[WIDTH-1:0];
        end
        ex_d = (pay_s2 > WIDTH'(0)) && (pay_s2 >= c_sat);
    end

    // Stage 3 register: result outputs, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            exercise_out <= 1'b0;
            cf_out       <= '0;
            path_idx_out <= '0;
        end else if (en) begin
            valid_out    <= v_s2;
            exercise_out <= ex_d;
            cf_out       <= ex_d ? pay_s2 : cf_s2;
            path_idx_out <= idx_s2;
        end
    end

endmodule

// File: tb/tb_exercise_decision.sv
// Testbench for exercise_decision: scenario tasks with inline checks against
// an exact wide-integer model of the regression and exercise rule.
module tb_exercise_decision;

    localparam int W  = 32;
    localparam int QF = 16;
    localparam int N  = 10;
    localparam int IW = $clog2(N) + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                beta_valid = 1'b0;
    logic                beta_ready;
    logic signed [W-1:0] beta [0:2];
    logic                valid_in = 1'b0;
    logic                ready_out;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] payoff_in = '0;
    logic signed [W-1:0] cf_in = '0;
    logic                valid_out;
    logic                ready_in = 1'b1;
    logic signed [W-1:0] cf_out;
    logic                exercise_out;
    logic [IW-1:0]       path_idx_out;
    logic                done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic signed [W-1:0] cf;
        logic                ex;
        int                  idx;
    } exp_t;

    exp_t                expq[$];
    logic signed [W-1:0] smp_x [N];
    logic signed [W-1:0] smp_p [N];
    logic signed [W-1:0] smp_c [N];
    logic signed [W-1:0] res_cf [N];
    logic                res_ex [N];

    exercise_decision #(
        .WIDTH  (W),
        .QINT   (16),
        .QFRAC  (QF),
        .N_PATHS(N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .beta_valid  (beta_valid),
        .beta_ready  (beta_ready),
        .beta        (beta),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .x_in        (x_in),
        .payoff_in   (payoff_in),
        .cf_in       (cf_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .cf_out      (cf_out),
        .exercise_out(exercise_out),
        .path_idx_out(path_idx_out),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Continuation value from the regression with exact integers, floor shifts, saturation.
    function automatic logic signed [W-1:0] model_c(input logic signed [W-1:0] b0, b1, b2, x);
        logic signed [127:0] xx, x2, c, hi, lo;
        xx = 128'(x);
        x2 = (xx * xx) >>> QF;
        c  = 128'(b0) + ((128'(b1) * xx) >>> QF) + ((128'(b2) * x2) >>> QF);
        hi = (128'sd1 <<< (W - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (W - 1));
        if (c > hi) return W'(hi);
        if (c < lo) return W'(lo);
        return W'(c);
    endfunction

    function automatic logic signed [W-1:0] rnd_s(input int r);
        int v;
        v = $urandom_range(0, 2 * r);
        return W'(v - r);
    endfunction

    task automatic fill_random(input logic signed [W-1:0] b0, b1, b2);
        for (int i = 0; i < N; i++) begin
            smp_x[i] = rnd_s(1 << 22);
            smp_c[i] = rnd_s(1 << 24);
            case ($urandom_range(0, 3))
                0:       smp_p[i] = model_c(b0, b1, b2, smp_x[i]);
                1:       smp_p[i] = '0;
                default: smp_p[i] = rnd_s(1 << 24);
            endcase
        end
    endtask

    task automatic load_beta(input logic signed [W-1:0] b0, b1, b2, output bit ok);
        @(negedge clk);
        beta[0] = b0;
        beta[1] = b1;
        beta[2] = b2;
        beta_valid = 1'b1;
        #1;
        ok = (beta_ready === 1'b1);
        @(negedge clk);
        beta_valid = 1'b0;
    endtask

    // Streams smp_* through the DUT and checks each result, stalls, latency and done.
    task automatic run_batch(input logic signed [W-1:0] eb0, eb1, eb2, input bit stalls,
                             input bit hold_beta, input logic signed [W-1:0] nb0, nb1, nb2);
        bit                  stall_at [128];
        int                  sent, got, dones, extra, cyc, last_cyc;
        int                  acc_cyc [N];
        bit                  prev_stall;
        logic signed [W-1:0] h_cf, ce;
        logic                h_ex;
        logic [IW-1:0]       h_idx;
        exp_t                e, o;
        sent = 0; got = 0; dones = 0; extra = 0; cyc = 0; last_cyc = -10;
        prev_stall = 1'b0; h_cf = '0; h_ex = 1'b0; h_idx = '0;
        expq.delete();
        for (int k = 0; k < 128; k++) stall_at[k] = 1'b0;
        if (stalls) begin
            for (int k = 0; k < 5; k++) begin
                int s, l;
                s = $urandom_range(2, 30);
                l = $urandom_range(1, 4);
                for (int j = 0; j < l; j++) stall_at[s + j] = 1'b1;
            end
        end
        while (!(got == N && cyc > last_cyc + 2) && cyc < 400) begin
            @(negedge clk);
            ready_in = (cyc < 128) ? !stall_at[cyc] : 1'b1;
            valid_in = (got < N);
            if (sent < N) begin
                x_in = smp_x[sent]; payoff_in = smp_p[sent]; cf_in = smp_c[sent];
            end else begin
                x_in = rnd_s(1 << 22); payoff_in = rnd_s(1 << 22); cf_in = rnd_s(1 << 22);
            end
            if (hold_beta) begin
                beta_valid = 1'b1; beta[0] = nb0; beta[1] = nb1; beta[2] = nb2;
            end
            #1;
            if (got < N) begin
                n_cmp++;
                if (beta_ready !== 1'b0) begin
                    n_bad++; $display("FAIL beta_ready_busy: got %b expected 0 (cycle %0d)", beta_ready, cyc);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (valid_out !== 1'b1 || cf_out !== h_cf || exercise_out !== h_ex || path_idx_out !== h_idx) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b cf=%h ex=%b idx=%0d expected v=1 cf=%h ex=%b idx=%0d",
                             valid_out, cf_out, exercise_out, path_idx_out, h_cf, h_ex, h_idx);
                end
            end
            if (valid_in && ready_out) begin
                if (sent < N) begin
                    ce    = model_c(eb0, eb1, eb2, x_in);
                    e.ex  = (payoff_in > 0) && (payoff_in >= ce);
                    e.cf  = e.ex ? payoff_in : cf_in;
                    e.idx = sent;
                    expq.push_back(e);
                    acc_cyc[sent] = cyc;
                    sent++;
                end else begin
                    extra++;
                end
            end
            if (valid_out === 1'b1 && ready_in) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL unexpected_output: got idx=%0d expected no output", path_idx_out);
                end else begin
                    o = expq.pop_front();
                    if (cf_out !== o.cf || exercise_out !== o.ex || path_idx_out !== IW'(o.idx)) begin
                        n_bad++;
                        $display("FAIL result: got cf=%h ex=%b idx=%0d expected cf=%h ex=%b idx=%0d",
                                 cf_out, exercise_out, path_idx_out, o.cf, o.ex, o.idx);
                    end
                    if (!stalls) begin
                        n_cmp++;
                        if (cyc - acc_cyc[o.idx] != 3) begin
                            n_bad++; $display("FAIL latency: got %0d expected 3", cyc - acc_cyc[o.idx]);
                        end
                    end
                    res_cf[o.idx] = cf_out;
                    res_ex[o.idx] = exercise_out;
                end
                got++;
                if (got == N) last_cyc = cyc;
            end
            if (done === 1'b1) begin
                dones++;
                n_cmp++;
                if (!(got == N && cyc == last_cyc + 1)) begin
                    n_bad++; $display("FAIL done_timing: got pulse at cycle %0d expected %0d", cyc, last_cyc + 1);
                end
            end
            prev_stall = (valid_out === 1'b1) && !ready_in;
            h_cf = cf_out; h_ex = exercise_out; h_idx = path_idx_out;
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        n_cmp++;
        if (got != N) begin n_bad++; $display("FAIL batch_count: got %0d outputs expected %0d", got, N); end
        n_cmp++;
        if (dones != 1) begin n_bad++; $display("FAIL done_pulses: got %0d expected 1", dones); end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL drain_accept: got %0d extra accepts expected 0", extra); end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || done !== 1'b0 || ready_out !== 1'b0 || cf_out !== '0 ||
            exercise_out !== 1'b0 || path_idx_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%b ro=%b cf=%h ex=%b idx=%0d expected all 0",
                     valid_out, done, ready_out, cf_out, exercise_out, path_idx_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (beta_ready !== 1'b1) begin n_bad++; $display("FAIL reset_beta_ready: got %b expected 1", beta_ready); end
        n_cmp++;
        if (ready_out !== 1'b0) begin n_bad++; $display("FAIL idle_ready_out: got %b expected 0", ready_out); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (valid_out !== 1'b0) begin n_bad++; $display("FAIL idle_no_accept: got valid_out %b expected 0", valid_out); end
        valid_in = 1'b0;
    endtask

    task automatic test_known_vectors();
        bit ok;
        smp_x[0] = 32'sh00020000; smp_p[0] = 32'sh00030000; smp_c[0] = 32'sh00010000;
        smp_x[1] = 32'sh00020000; smp_p[1] = 32'sh00020000; smp_c[1] = 32'sh00005000;
        smp_x[2] = 32'shFFFC0000; smp_p[2] = 32'sh00000000; smp_c[2] = 32'sh00001234;
        smp_x[3] = 32'shFFFC0000; smp_p[3] = 32'shFFFF8000; smp_c[3] = 32'sh00004321;
        smp_x[4] = 32'sh00000000; smp_p[4] = 32'sh00010000; smp_c[4] = 32'sh00000007;
        smp_x[5] = 32'sh00000000; smp_p[5] = 32'sh0000FFFF; smp_c[5] = 32'sh00000009;
        for (int i = 6; i < N; i++) begin
            smp_x[i] = rnd_s(1 << 20); smp_p[i] = rnd_s(1 << 19); smp_c[i] = rnd_s(1 << 19);
        end
        load_beta(32'sh00010000, 32'sh00008000, 32'sh0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL known_load: got beta_ready 0 expected 1"); end
        run_batch(32'sh00010000, 32'sh00008000, 32'sh0, 1'b0, 1'b0, '0, '0, '0);
        n_cmp++;
        if (res_cf[0] !== 32'sh00030000 || res_ex[0] !== 1'b1) begin
            n_bad++; $display("FAIL known_exercise: got cf=%h ex=%b expected cf=00030000 ex=1", res_cf[0], res_ex[0]);
        end
        n_cmp++;
        if (res_cf[1] !== 32'sh00020000 || res_ex[1] !== 1'b1) begin
            n_bad++; $display("FAIL known_tie: got cf=%h ex=%b expected cf=00020000 ex=1", res_cf[1], res_ex[1]);
        end
        n_cmp++;
        if (res_cf[2] !== 32'sh00001234 || res_ex[2] !== 1'b0) begin
            n_bad++; $display("FAIL known_zero_payoff: got cf=%h ex=%b expected cf=00001234 ex=0", res_cf[2], res_ex[2]);
        end
        n_cmp++;
        if (res_cf[3] !== 32'sh00004321 || res_ex[3] !== 1'b0) begin
            n_bad++; $display("FAIL known_neg_payoff: got cf=%h ex=%b expected cf=00004321 ex=0", res_cf[3], res_ex[3]);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        for (int i = 0; i < N; i++) begin
            smp_x[i] = W'($urandom); smp_p[i] = W'($urandom); smp_c[i] = W'($urandom);
        end
        smp_x[0] = 32'sh7FFF0000; smp_p[0] = 32'sh7FFFFFFF; smp_c[0] = 32'sh00000005;
        smp_x[1] = 32'sh7FFF0000; smp_p[1] = 32'sh7FFFFFFE; smp_c[1] = 32'sh00000006;
        load_beta(32'sh0, 32'sh0, 32'sh7FFF0000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL sat_load: got beta_ready 0 expected 1"); end
        run_batch(32'sh0, 32'sh0, 32'sh7FFF0000, 1'b0, 1'b0, '0, '0, '0);
        n_cmp++;
        if (res_cf[0] !== 32'sh7FFFFFFF || res_ex[0] !== 1'b1) begin
            n_bad++; $display("FAIL sat_max_tie: got cf=%h ex=%b expected cf=7FFFFFFF ex=1", res_cf[0], res_ex[0]);
        end
        n_cmp++;
        if (res_cf[1] !== 32'sh00000006 || res_ex[1] !== 1'b0) begin
            n_bad++; $display("FAIL sat_max_below: got cf=%h ex=%b expected cf=00000006 ex=0", res_cf[1], res_ex[1]);
        end
        smp_x[0] = 32'sh40000000; smp_p[0] = 32'sh00000001; smp_c[0] = 32'sh00000011;
        smp_x[1] = 32'sh40000000; smp_p[1] = 32'sh00000000; smp_c[1] = 32'sh00000022;
        load_beta(32'sh0, 32'sh0, 32'sh80000000, ok);
        run_batch(32'sh0, 32'sh0, 32'sh80000000, 1'b0, 1'b0, '0, '0, '0);
        n_cmp++;
        if (res_cf[0] !== 32'sh00000001 || res_ex[0] !== 1'b1) begin
            n_bad++; $display("FAIL sat_min: got cf=%h ex=%b expected cf=00000001 ex=1", res_cf[0], res_ex[0]);
        end
        n_cmp++;
        if (res_cf[1] !== 32'sh00000022 || res_ex[1] !== 1'b0) begin
            n_bad++; $display("FAIL sat_min_zero: got cf=%h ex=%b expected cf=00000022 ex=0", res_cf[1], res_ex[1]);
        end
    endtask

    task automatic test_random_batches();
        bit ok;
        logic signed [W-1:0] b0, b1, b2;
        for (int r = 0; r < 3; r++) begin
            b0 = rnd_s(1 << 20); b1 = rnd_s(1 << 18); b2 = rnd_s(1 << 16);
            fill_random(b0, b1, b2);
            load_beta(b0, b1, b2, ok);
            run_batch(b0, b1, b2, 1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic signed [W-1:0] b0, b1, b2;
        for (int r = 0; r < 2; r++) begin
            b0 = rnd_s(1 << 20); b1 = rnd_s(1 << 18); b2 = rnd_s(1 << 16);
            fill_random(b0, b1, b2);
            load_beta(b0, b1, b2, ok);
            run_batch(b0, b1, b2, 1'b1, 1'b0, '0, '0, '0);
        end
    endtask

    task automatic test_reset_mid_eval();
        bit ok;
        int acc, seen;
        logic signed [W-1:0] b0, b1, b2;
        b0 = rnd_s(1 << 20); b1 = rnd_s(1 << 18); b2 = rnd_s(1 << 16);
        load_beta(b0, b1, b2, ok);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'b1; ready_in = 1'b1;
            x_in = rnd_s(1 << 20); payoff_in = rnd_s(1 << 20); cf_in = rnd_s(1 << 20);
            #1;
            if (ready_out) acc++;
        end
        n_cmp++;
        if (acc != 4) begin n_bad++; $display("FAIL pre_reset_accepts: got %0d expected 4", acc); end
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || path_idx_out !== '0 || cf_out !== '0) begin
            n_bad++; $display("FAIL mid_reset: got v=%b idx=%0d cf=%h expected 0 0 0", valid_out, path_idx_out, cf_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (beta_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_beta_ready: got %b expected 1", beta_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (valid_out !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL flushed_samples: got %0d valid cycles expected 0", seen); end
        b0 = rnd_s(1 << 20); b1 = rnd_s(1 << 18); b2 = rnd_s(1 << 16);
        fill_random(b0, b1, b2);
        load_beta(b0, b1, b2, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL post_reset_load: got beta_ready 0 expected 1"); end
        run_batch(b0, b1, b2, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_beta_during_eval();
        bit ok;
        logic signed [W-1:0] a0, a1, a2, n0, n1, n2;
        a0 = rnd_s(1 << 20); a1 = rnd_s(1 << 18); a2 = rnd_s(1 << 16);
        n0 = rnd_s(1 << 20); n1 = rnd_s(1 << 18); n2 = rnd_s(1 << 16);
        fill_random(a0, a1, a2);
        load_beta(a0, a1, a2, ok);
        run_batch(a0, a1, a2, 1'b0, 1'b1, n0, n1, n2);
        n_cmp++;
        if (beta_ready !== 1'b0) begin
            n_bad++; $display("FAIL held_beta_latched: got beta_ready %b expected 0", beta_ready);
        end
        beta_valid = 1'b0;
        fill_random(n0, n1, n2);
        run_batch(n0, n1, n2, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        beta[0] = '0;
        beta[1] = '0;
        beta[2] = '0;
        test_reset();
        test_known_vectors();
        test_saturation();
        test_random_batches();
        test_back_to_back();
        test_reset_mid_eval();
        test_beta_during_eval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
